// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one memory request per load/store, aligns store lanes, extends loads, counts branch hits/misses.
// Latency: non-memory/misaligned ops 1 cycle; aligned load/store 1 cycle after mem_resp_i (or abort after TIMEOUT_CYC busy cycles).
// Backpressure: in_ready_o is low while a request is outstanding; mem_resp_i while idle is ignored.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   in_*_i / in_ready_o      EX/MEM side: valid/ready handshake plus opcode, funct3, address, store data, rd, branch info
//   mem_*_o / mem_*_i        memory side: read/write request held until mem_resp_i, word address, lane data, byte enables
//   out_*_o                  MEM/WB side: one-cycle out_valid_o pulse with rd, data and misaligned/timeout flags
//   cnt_clear_i, *_count_o   saturating branch-prediction hit/miss counters

module mem_stage_lsu #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [6:0]        in_opcode_i,
  input  logic [2:0]        in_funct3_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [31:0]       in_wdata_i,
  input  logic [4:0]        in_rd_i,
  input  logic              in_br_en_i,
  input  logic              in_prediction_i,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_byte_enable_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_resp_i,
  output logic              out_valid_o,
  output logic [4:0]        out_rd_o,
  output logic [31:0]       out_data_o,
  output logic              out_misaligned_o,
  output logic              out_timeout_o,
  input  logic              cnt_clear_i,
  output logic [CNT_W-1:0]  hit_count_o,
  output logic [CNT_W-1:0]  miss_count_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  // Counter only needs to reach TIMEOUT_CYC-1; the abort fires on that busy cycle.
  localparam int unsigned TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]  mem_address_q, mem_address_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic               out_valid_q, out_valid_d;
  logic [4:0]         out_rd_q, out_rd_d;
  logic [31:0]        out_data_q, out_data_d;
  logic               out_mis_q, out_mis_d;
  logic               out_tmo_q, out_tmo_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         off_q, off_d;
  logic [4:0]         rd_q, rd_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic [CNT_W-1:0]   miss_q, miss_d;

  logic        accept;
  logic        is_load, is_store, is_br;
  logic        misaligned;
  logic [3:0]  be_new;
  logic [31:0] rd_shift;
  logic [31:0] ld_data;

  assign accept   = in_valid_i && (state_q == IDLE);
  assign is_load  = (in_opcode_i == OP_LOAD);
  assign is_store = (in_opcode_i == OP_STORE);
  assign is_br    = (in_opcode_i == OP_BR);

  // funct3[1:0]: 00 byte, 01 half, 1x word; funct3[2] selects zero-extension.
  always_comb begin
    misaligned = 1'b0;
    be_new     = 4'b1111;
    case (in_funct3_i[1:0])
      2'b00: begin
        be_new = 4'b0001 << in_addr_i[1:0];
      end
      2'b01: begin
        be_new     = 4'b0011 << in_addr_i[1:0];
        misaligned = in_addr_i[0];
      end
      default: begin
        be_new     = 4'b1111;
        misaligned = (in_addr_i[1:0] != 2'b00);
      end
    endcase
  end

  // Load return: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    rd_shift = mem_rdata_i >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_data = {24'd0, rd_shift[7:0]};
      3'b101:  ld_data = {16'd0, rd_shift[15:0]};
      default: ld_data = rd_shift;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    out_valid_d   = 1'b0;
    out_rd_d      = out_rd_q;
    out_data_d    = out_data_q;
    out_mis_d     = 1'b0;
    out_tmo_d     = 1'b0;
    funct3_d      = funct3_q;
    off_d         = off_q;
    rd_d          = rd_q;
    tmo_d         = tmo_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!(is_load || is_store)) begin
            out_valid_d = 1'b1;
            out_data_d  = 32'(in_addr_i);
            out_rd_d    = in_rd_i;
          end else if (misaligned) begin
            out_valid_d = 1'b1;
            out_mis_d   = 1'b1;
            out_data_d  = 32'd0;
            out_rd_d    = in_rd_i;
          end else begin
            state_d       = BUSY;
            mem_read_d    = is_load;
            mem_write_d   = is_store;
            mem_address_d = {in_addr_i[ADDR_W-1:2], 2'b00};
            mem_wdata_d   = in_wdata_i << {in_addr_i[1:0], 3'b000};
            mem_be_d      = be_new;
            funct3_d      = in_funct3_i;
            off_d         = in_addr_i[1:0];
            rd_d          = in_rd_i;
            tmo_d         = '0;
          end
        end
      end
      BUSY: begin
        // mem_resp_i is checked first so a response on the last allowed cycle still completes normally.
        if (mem_resp_i) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          out_valid_d = 1'b1;
          out_rd_d    = rd_q;
          out_data_d  = mem_read_q ? ld_data : 32'd0;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          out_valid_d = 1'b1;
          out_tmo_d   = 1'b1;
          out_rd_d    = rd_q;
          out_data_d  = 32'd0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Branch counters: clear beats increment, increments stop at all-ones.
  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (cnt_clear_i) begin
      hit_d  = '0;
      miss_d = '0;
    end else if (accept && is_br) begin
      if (in_br_en_i == in_prediction_i) begin
        if (!(&hit_q)) hit_d = hit_q + CNT_W'(1);
      end else begin
        if (!(&miss_q)) miss_d = miss_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      out_valid_q   <= 1'b0;
      out_rd_q      <= '0;
      out_data_q    <= '0;
      out_mis_q     <= 1'b0;
      out_tmo_q     <= 1'b0;
      funct3_q      <= '0;
      off_q         <= '0;
      rd_q          <= '0;
      tmo_q         <= '0;
      hit_q         <= '0;
      miss_q        <= '0;
    end else begin
      state_q       <= state_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      out_valid_q   <= out_valid_d;
      out_rd_q      <= out_rd_d;
      out_data_q    <= out_data_d;
      out_mis_q     <= out_mis_d;
      out_tmo_q     <= out_tmo_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      rd_q          <= rd_d;
      tmo_q         <= tmo_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
    end
  end

  assign in_ready_o        = (state_q == IDLE);
  assign mem_read_o        = mem_read_q;
  assign mem_write_o       = mem_write_q;
  assign mem_address_o     = mem_address_q;
  assign mem_wdata_o       = mem_wdata_q;
  assign mem_byte_enable_o = mem_be_q;
  assign out_valid_o       = out_valid_q;
  assign out_rd_o          = out_rd_q;
  assign out_data_o        = out_data_q;
  assign out_misaligned_o  = out_mis_q;
  assign out_timeout_o     = out_tmo_q;
  assign hit_count_o       = hit_q;
  assign miss_count_o      = miss_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam int CNT_W   = 2;
  localparam int TMO     = 4;
  localparam int MAXC    = (1 << CNT_W) - 1;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [6:0] in_opcode = '0;
  logic [2:0] in_funct3 = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [4:0] in_rd = '0;
  logic in_br_en = 1'b0;
  logic in_prediction = 1'b0;
  logic mem_read, mem_write;
  logic [31:0] mem_address, mem_wdata;
  logic [3:0] mem_be;
  logic [31:0] mem_rdata = '0;
  logic mem_resp = 1'b0;
  logic out_valid;
  logic [4:0] out_rd;
  logic [31:0] out_data;
  logic out_mis, out_tmo;
  logic cnt_clear = 1'b0;
  logic [CNT_W-1:0] hit_count, miss_count;

  mem_stage_lsu #(.CNT_W(CNT_W), .TIMEOUT_CYC(TMO), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_opcode_i(in_opcode), .in_funct3_i(in_funct3), .in_addr_i(in_addr),
    .in_wdata_i(in_wdata), .in_rd_i(in_rd),
    .in_br_en_i(in_br_en), .in_prediction_i(in_prediction),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_address_o(mem_address),
    .mem_wdata_o(mem_wdata), .mem_byte_enable_o(mem_be),
    .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp),
    .out_valid_o(out_valid), .out_rd_o(out_rd), .out_data_o(out_data),
    .out_misaligned_o(out_mis), .out_timeout_o(out_tmo),
    .cnt_clear_i(cnt_clear), .hit_count_o(hit_count), .miss_count_o(miss_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  logic m_busy = 1'b0;
  logic m_load = 1'b0;
  int   m_hit = 0;
  int   m_miss = 0;
  logic chk_en = 1'b0;

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rdat, input int off, input logic [2:0] f3);
    longint v, lim;
    int nb;
    nb  = nbytes(f3);
    lim = 64'sd1 << (8 * nb);
    v   = (longint'(rdat) >> (8 * off)) % lim;
    if (!f3[2] && nb < 4 && v >= lim / 2) v = v - lim;
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_be(input int off, input logic [2:0] f3);
    int m;
    m = ((1 << nbytes(f3)) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input int off);
    longint w;
    w = longint'(wd) << (8 * off);
    return w[31:0];
  endfunction

  // One compare process: outputs checked against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_valid", out_valid, 1);
        check("out_rd", out_rd, e.rd);
        check("out_data", out_data, e.data);
        check("out_misaligned", out_mis, e.mis);
        check("out_timeout", out_tmo, e.tmo);
      end else begin
        check("out_valid_quiet", out_valid, 0);
      end
      check("in_ready", in_ready, !m_busy);
      check("mem_read", mem_read, m_busy && m_load);
      check("mem_write", mem_write, m_busy && !m_load);
      check("hit_count", hit_count, m_hit);
      check("miss_count", miss_count, m_miss);
    end
  end

  // ---------------- stimulus tasks (called just after a rising edge) ----------------
  task automatic nonmem(input logic [6:0] op, input logic [31:0] addr, input logic [4:0] rd,
                        input logic br, input logic pred, input logic clr);
    in_opcode = op; in_addr = addr; in_rd = rd; in_funct3 = 3'b000;
    in_br_en = br; in_prediction = pred; in_valid = 1'b1; cnt_clear = clr;
    exp_q.push_back('{cyc + 1, rd, addr, 1'b0, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0; cnt_clear = 1'b0;
    if (clr) begin
      m_hit = 0; m_miss = 0;
    end else if (op == OP_BR) begin
      if (br == pred) m_hit = (m_hit == MAXC) ? MAXC : m_hit + 1;
      else            m_miss = (m_miss == MAXC) ? MAXC : m_miss + 1;
    end
  endtask

  // dly: busy cycles before mem_resp is raised; negative means never respond.
  task automatic memop(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input logic [4:0] rd,
                       input int dly, input logic lit_en, input logic [3:0] lit_be,
                       input logic [31:0] lit_wdata);
    int off;
    off = addr % 4;
    in_opcode = st ? OP_STORE : OP_LOAD; in_funct3 = f3; in_addr = addr;
    in_wdata = wdata; in_rd = rd; in_valid = 1'b1;
    if ((addr % nbytes(f3)) != 0) begin
      exp_q.push_back('{cyc + 1, rd, 32'd0, 1'b1, 1'b0});
      @(posedge clk); #1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    m_busy = 1'b1; m_load = !st;
    // A branch offered while busy must be neither accepted nor counted.
    in_opcode = OP_BR; in_br_en = 1'b1; in_prediction = 1'b0; in_addr = 32'hFFFF_FFFF;
    check("mem_address", mem_address, addr - (addr % 4));
    check("mem_byte_enable", mem_be, exp_be(off, f3));
    check("mem_wdata", mem_wdata, exp_wdata(wdata, off));
    if (lit_en) begin
      check("lit_byte_enable", mem_be, lit_be);
      check("lit_wdata", mem_wdata, lit_wdata);
    end
    if (dly < 0) begin
      exp_q.push_back('{cyc + TMO, rd, 32'd0, 1'b0, 1'b1});
      repeat (TMO) begin
        @(posedge clk); #1;
      end
    end else begin
      repeat (dly) begin
        @(posedge clk); #1;
        check("mem_address_hold", mem_address, addr - (addr % 4));
      end
      mem_resp = 1'b1; mem_rdata = rdata;
      exp_q.push_back('{cyc + 1, rd, st ? 32'd0 : exp_load(rdata, off, f3), 1'b0, 1'b0});
      @(posedge clk); #1;
      mem_resp = 1'b0; mem_rdata = $urandom;
    end
    in_valid = 1'b0;
    m_busy = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_misaligned", out_mis, 0);
    check("rst_out_timeout", out_tmo, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_byte_enable", mem_be, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    check("rst_in_ready", in_ready, 1);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Non-memory op passes address through in one cycle
    nonmem(OP_ALU, 32'h1234_5678, 5'd7, 1'b0, 1'b0, 1'b0);
    nonmem(OP_ALU, 32'h0000_0001, 5'd8, 1'b0, 1'b0, 1'b0);

    // LB 0x1003, response after 3 busy cycles
    memop(1'b0, 3'b000, 32'h1003, 32'h0, 32'h8056_3412, 5'd1, 3, 1'b1, 4'b1000, 32'h0);
    check("lit_lb_valid", out_valid, 1);
    check("lit_lb_data", out_data, 32'hFFFF_FF80);

    // SH 0x2002
    memop(1'b1, 3'b001, 32'h2002, 32'h0000_ABCD, 32'h0, 5'd2, 1, 1'b1, 4'b1100, 32'hABCD_0000);
    check("lit_sh_data", out_data, 32'h0);

    // LW 0x3001 misaligned
    memop(1'b0, 3'b010, 32'h3001, 32'h0, 32'h0, 5'd3, 0, 1'b0, 4'b0, 32'h0);
    check("lit_lw_misaligned", out_mis, 1);

    // Widths, signedness and lanes
    memop(1'b0, 3'b100, 32'h1002, 32'h0, 32'h12F4_5678, 5'd4, 0, 1'b0, 4'b0, 32'h0);
    check("lit_lbu_data", out_data, 32'h0000_00F4);
    memop(1'b0, 3'b001, 32'h1002, 32'h0, 32'h8001_0000, 5'd5, 0, 1'b0, 4'b0, 32'h0);
    check("lit_lh_data", out_data, 32'hFFFF_8001);
    memop(1'b0, 3'b101, 32'h1002, 32'h0, 32'h8001_0000, 5'd6, 2, 1'b0, 4'b0, 32'h0);
    check("lit_lhu_data", out_data, 32'h0000_8001);
    memop(1'b0, 3'b010, 32'h1000, 32'h0, 32'hDEAD_BEEF, 5'd9, 0, 1'b0, 4'b0, 32'h0);
    memop(1'b0, 3'b000, 32'h1001, 32'h0, 32'h0000_7F00, 5'd10, 0, 1'b0, 4'b0, 32'h0);
    memop(1'b1, 3'b000, 32'h4001, 32'h0000_0055, 32'h0, 5'd11, 0, 1'b1, 4'b0010, 32'h0000_5500);
    memop(1'b1, 3'b010, 32'h4000, 32'hCAFE_F00D, 32'h0, 5'd12, 1, 1'b1, 4'b1111, 32'hCAFE_F00D);
    memop(1'b0, 3'b001, 32'h1001, 32'h0, 32'h0, 5'd13, 0, 1'b0, 4'b0, 32'h0);
    memop(1'b1, 3'b010, 32'h4002, 32'h1, 32'h0, 5'd14, 0, 1'b0, 4'b0, 32'h0);

    // Timeout, then response on the last allowed busy cycle
    memop(1'b0, 3'b010, 32'h5000, 32'h0, 32'h0, 5'd15, -1, 1'b0, 4'b0, 32'h0);
    check("lit_timeout_flag", out_tmo, 1);
    memop(1'b0, 3'b010, 32'h5004, 32'h0, 32'h1357_9BDF, 5'd16, TMO - 1, 1'b0, 4'b0, 32'h0);
    check("lit_late_resp_timeout", out_tmo, 0);
    check("lit_late_resp_data", out_data, 32'h1357_9BDF);

    // mem_resp while idle is ignored
    mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_resp = 1'b0;
    @(posedge clk); #1;

    // Branch counters: saturation, then clear beating a same-cycle branch
    repeat (5) nonmem(OP_BR, 32'h0000_0100, 5'd0, 1'b1, 1'b1, 1'b0);
    check("lit_hit_saturated", hit_count, 3);
    nonmem(OP_BR, 32'h0000_0104, 5'd0, 1'b1, 1'b0, 1'b0);
    nonmem(OP_BR, 32'h0000_0108, 5'd0, 1'b0, 1'b1, 1'b0);
    check("lit_miss_two", miss_count, 2);
    nonmem(OP_BR, 32'h0000_010C, 5'd0, 1'b1, 1'b1, 1'b1);
    check("lit_clear_hit", hit_count, 0);
    check("lit_clear_miss", miss_count, 0);
    nonmem(OP_BR, 32'h0000_0110, 5'd0, 1'b0, 1'b0, 1'b0);
    nonmem(OP_BR, 32'h0000_0114, 5'd0, 1'b0, 1'b1, 1'b0);

    // Reset while a load is outstanding
    in_opcode = OP_LOAD; in_funct3 = 3'b010; in_addr = 32'h6000; in_rd = 5'd17; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; m_busy = 1'b1; m_load = 1'b1;
    check("busy_before_reset", mem_read, 1);
    chk_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_drops_mem_read", mem_read, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_hit_count", hit_count, 0);
    check("reset_miss_count", miss_count, 0);
    m_busy = 1'b0; m_hit = 0; m_miss = 0; exp_q.delete();
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_reset_in_ready", in_ready, 1);
    check("after_reset_no_output", out_valid, 0);
    chk_en = 1'b1;
    mem_resp = 1'b1;
    @(posedge clk); #1;
    mem_resp = 1'b0;
    nonmem(OP_ALU, 32'hA5A5_0000, 5'd31, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end

    if (exp_q.size() != 0) check("pending_outputs", exp_q.size(), 0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
